product_accumulator: RTL
========================

Name: product_accumulator

Overview:
- Downstream consumer of the 16x16 combinational multiplier (array_multiplier_cla).
- Accepts a stream of 32-bit products over a valid/ready handshake and sums them into a saturating wide accumulator.
- A frame ends on a beat flagged last. The frame result (sum, beat count, overflow flag) is then presented on an output valid/ready handshake.
- Forms the accumulate half of the team's MAC datapath.

Parameters:
- PROD_W, 32, width of incoming product (equals multiplier output width)
- ACC_W, 40, accumulator/result width; must be >= PROD_W
- CNT_W, 16, width of per-frame beat counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous abort: discard partial frame
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_product  input  PROD_W  unsigned product from multiplier
- in_last  input  1  beat is final beat of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_acc  output  ACC_W  saturated frame sum
- out_count  output  CNT_W  number of beats in frame (saturating)
- out_ovf  output  1  frame sum saturated

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and on release, all of the following hold:
  - state=ACCUM; internal acc=0, cnt=0, ovf=0
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0
  - in_ready=0 while rst=1
- in_ready = (state==ACCUM) & ~rst. This is combinational from the registered state only; there is no dependency on in_valid.
- Accept occurs when in_valid & in_ready at a rising edge.
- State ACCUM:
  - Accept with in_last=0:
    - acc <= sat(acc + in_product)
    - cnt <= min(cnt+1, 2^CNT_W-1)
    - ovf <= ovf | carry
  - Accept with in_last=1:
    - out_acc <= sat(acc + in_product); out_count <= min(cnt+1, max); out_ovf <= ovf | carry
    - out_valid <= 1; internal acc, cnt, ovf <= 0; state <= DONE
  - Saturation: if the unsigned (ACC_W+1)-bit sum >= 2^ACC_W, the result becomes all-ones and carry=1.
  - Latency: last beat accepted at edge N, so out_valid=1 from edge N onward (visible in cycle N+1).
  - clr=1 with no accept: acc, cnt, ovf <= 0.
  - clr=1 with a simultaneous accept: the partial frame is discarded and the beat starts a new frame.
    - acc <= in_product; cnt <= 1; ovf <= 0.
    - If in_last=1, a single-beat result is produced.
- State DONE:
  - in_ready=0; out_valid=1.
  - out_acc, out_count and out_ovf are held stable until the handshake completes.
  - out_valid & out_ready at an edge: out_valid <= 0; state <= ACCUM. in_ready returns to 1 in the following cycle, giving a one-cycle bubble per frame.
  - clr is ignored in DONE; the result is never dropped.
- Width rules:
  - in_product is zero-extended to ACC_W+1 before the add.
  - out_count saturates at 2^CNT_W-1 and does not wrap.
- No combinational path from any input to any output except rst to in_ready.
- Reset mid-frame or in DONE: everything returns to reset values immediately, and a pending result is lost.

Test Plan:
- Reset then stream 3,5,7 (last on 7), out_ready=1 → out_valid one cycle after the last accept; out_acc=15, out_count=3, out_ovf=0; in_ready low exactly during DONE.
- Single beat 0xFFFE0001 with last → out_acc=0xFFFE0001, out_count=1; a second frame 2,2(last) afterwards gives 4, proving the accumulator was cleared.
- ACC_W=33, beats 0xFFFFFFFF ×3 (last on third) → out_acc=0x1FFFFFFFF, out_ovf=1, out_count=3; the next frame 1(last) gives out_acc=1, out_ovf=0.
- Backpressure: frame 10(last) with out_ready=0 for 5 cycles while in_valid=1 → in_ready=0, outputs hold 10/1/0 stable, no beat consumed; out_ready=1 → handshake completes and in_ready=1 in the next cycle.
- clr: beats 100,200, then clr alone, then 9(last) → out_acc=9, out_count=1. Repeat with clr coincident with beat 9(last) → same result. Assert clr during DONE → result unchanged.
- Async reset asserted mid-frame (after 2 beats) and in DONE, between clock edges → out_valid, out_acc, out_count and in_ready drop immediately; the next frame 4(last) gives 4/1.

Source files
------------

// File: rtl/product_accumulator.sv
// Saturating frame accumulator for the MAC datapath: sums a stream of unsigned
// products and presents the per-frame sum, beat count and overflow flag.
module product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [ACC_W-1:0]   base_acc;
  logic [CNT_W-1:0]   base_cnt;
  logic               base_ovf;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic [ACC_W-1:0]   sat_sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_new;

  assign in_ready  = (state_q == ACCUM) & ~rst;
  assign out_valid = (state_q == DONE);
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  assign accept = in_valid & in_ready;

  // A clr coinciding with a beat restarts the frame from that beat.
  assign base_acc = clr ? '0 : acc_q;
  assign base_cnt = clr ? '0 : cnt_q;
  assign base_ovf = clr ? 1'b0 : ovf_q;

  assign sum     = {1'b0, base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
  assign carry   = sum[ACC_W];
  assign sat_sum = carry ? ACC_MAX : sum[ACC_W-1:0];
  assign cnt_inc = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + 1'b1;
  assign ovf_new = base_ovf | carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (in_last) begin
            out_acc_d   = sat_sum;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_new;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d = sat_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_new;
          end
        end else if (clr) begin
          acc_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      DONE: begin
        // clr is deliberately ignored here so a finished result is never dropped.
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

endmodule
